// File: rtl/axi_conn_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module     : axi_conn_arbiter                                                |
// | Description: Two-requester round-robin owner of a shared AXI connector port; |
// |              tracks outstanding writes/reads and drains them before release. |
// |              Optional drain watchdog: define AXI_CONN_ARB_TIMEOUT_EN.        |
// | Revision   : 1.0                                                            |
// +-----------------------------------------------------------------------------+
module axi_conn_arbiter #(
   parameter int C_MAX_OUTSTANDING = 4,
   parameter int C_TIMEOUT_CYCLES  = 1024
) (
   input  logic       ACLK,
   input  logic       ARESETN,
   input  logic [1:0] REQ,
   output logic [1:0] GNT,
   output logic       ADDR_EN,
   input  logic       M_AXI_AWVALID,
   input  logic       M_AXI_AWREADY,
   input  logic       M_AXI_ARVALID,
   input  logic       M_AXI_ARREADY,
   input  logic       M_AXI_BVALID,
   input  logic       M_AXI_BREADY,
   input  logic       M_AXI_RVALID,
   input  logic       M_AXI_RREADY,
   input  logic       M_AXI_RLAST,
   output logic       TIMEOUT_ERR
);

   localparam int               CNT_W   = $clog2(C_MAX_OUTSTANDING + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(C_MAX_OUTSTANDING);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       gnt_q, gnt_d;
   logic             last_q, last_d;
   logic [CNT_W-1:0] wcnt_q, wcnt_d;
   logic [CNT_W-1:0] rcnt_q, rcnt_d;
   logic             win;
   logic             timeout_hit;

   logic aw_hs, ar_hs, b_hs, rlast_hs, owner_req, cnt_idle;

   assign aw_hs     = M_AXI_AWVALID & M_AXI_AWREADY;
   assign ar_hs     = M_AXI_ARVALID & M_AXI_ARREADY;
   assign b_hs      = M_AXI_BVALID & M_AXI_BREADY;
   assign rlast_hs  = M_AXI_RVALID & M_AXI_RREADY & M_AXI_RLAST;
   assign owner_req = gnt_q[1] ? REQ[1] : REQ[0];
   assign cnt_idle  = (wcnt_q == '0) && (rcnt_q == '0);

   // Simultaneous inc/dec cancels; lone steps past either end are dropped.
   function automatic logic [CNT_W-1:0] sat_step(input logic [CNT_W-1:0] cnt,
                                                 input logic inc, input logic dec);
      logic [CNT_W-1:0] res;
      res = cnt;
      if (inc && !dec && (cnt != CNT_MAX))
         res = cnt + CNT_W'(1);
      else if (dec && !inc && (cnt != '0))
         res = cnt - CNT_W'(1);
      return res;
   endfunction

   always_comb begin
      wcnt_d = timeout_hit ? '0 : sat_step(wcnt_q, aw_hs, b_hs);
      rcnt_d = timeout_hit ? '0 : sat_step(rcnt_q, ar_hs, rlast_hs);
   end

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      last_d  = last_q;
      win     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (REQ != 2'b00) begin
               win     = (REQ == 2'b11) ? ~last_q : REQ[1];
               gnt_d   = win ? 2'b10 : 2'b01;
               last_d  = win;
               state_d = ST_GRANT;
            end
         end
         ST_GRANT: begin
            if (!owner_req)
               state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (cnt_idle || timeout_hit) begin
               gnt_d   = 2'b00;
               state_d = ST_IDLE;
            end
         end
         default: begin
            gnt_d   = 2'b00;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_q <= ST_IDLE;
         gnt_q   <= 2'b00;
         last_q  <= 1'b1;
         wcnt_q  <= '0;
         rcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         last_q  <= last_d;
         wcnt_q  <= wcnt_d;
         rcnt_q  <= rcnt_d;
      end
   end

`ifdef AXI_CONN_ARB_TIMEOUT_EN
   localparam int              WD_W    = $clog2(C_TIMEOUT_CYCLES + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(C_TIMEOUT_CYCLES - 1);

   logic [WD_W-1:0] wd_q, wd_d;
   logic            resp_hs;

   assign resp_hs = b_hs | rlast_hs;
   // Fires during the cycle that completes C_TIMEOUT_CYCLES silent drain cycles.
   assign timeout_hit = (state_q == ST_DRAIN) && !cnt_idle && !resp_hs && (wd_q == WD_LAST);

   always_comb begin
      wd_d = '0;
      if ((state_q == ST_DRAIN) && !cnt_idle && !resp_hs && !timeout_hit)
         wd_d = wd_q + WD_W'(1);
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN)
         wd_q <= '0;
      else
         wd_q <= wd_d;
   end
`else
   assign timeout_hit = 1'b0;
`endif

   assign GNT         = gnt_q;
   assign ADDR_EN     = (state_q == ST_GRANT) && owner_req &&
                        (wcnt_q != CNT_MAX) && (rcnt_q != CNT_MAX);
   assign TIMEOUT_ERR = timeout_hit;

endmodule
`default_nettype wire

// File: tb/tb_axi_conn_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module     : tb_axi_conn_arbiter                                            |
// | Description: Directed and randomized bench for axi_conn_arbiter.           |
// | Revision   : 1.0                                                            |
// +-----------------------------------------------------------------------------+
module tb_axi_conn_arbiter;

   localparam int MAX = 4;
   localparam int TO  = 16;

   logic       ACLK = 1'b0;
   logic       ARESETN = 1'b0;
   logic [1:0] REQ = 2'b00;
   logic       awv = 1'b0, awr = 1'b0, arv = 1'b0, arr = 1'b0;
   logic       bv = 1'b0, br = 1'b0, rv = 1'b0, rr = 1'b0, rl = 1'b0;
   logic [1:0] GNT;
   logic       ADDR_EN, TIMEOUT_ERR;

   int checks = 0;
   int failures = 0;

   always #5 ACLK = ~ACLK;

   axi_conn_arbiter #(.C_MAX_OUTSTANDING(MAX), .C_TIMEOUT_CYCLES(TO)) dut (
      .ACLK(ACLK), .ARESETN(ARESETN), .REQ(REQ), .GNT(GNT), .ADDR_EN(ADDR_EN),
      .M_AXI_AWVALID(awv), .M_AXI_AWREADY(awr), .M_AXI_ARVALID(arv), .M_AXI_ARREADY(arr),
      .M_AXI_BVALID(bv), .M_AXI_BREADY(br), .M_AXI_RVALID(rv), .M_AXI_RREADY(rr),
      .M_AXI_RLAST(rl), .TIMEOUT_ERR(TIMEOUT_ERR)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model: owner / draining / counts ----------------
   int m_owner = -1;   // -1 means nobody owns the port
   int m_last  = 1;
   int m_w = 0, m_r = 0, m_wd = 0;
   bit m_drain = 1'b0;

   function automatic bit hs_aw();  return awv && awr;       endfunction
   function automatic bit hs_ar();  return arv && arr;       endfunction
   function automatic bit hs_b();   return bv && br;         endfunction
   function automatic bit hs_rl();  return rv && rr && rl;   endfunction

   function automatic bit exp_to();
`ifdef AXI_CONN_ARB_TIMEOUT_EN
      return (m_owner >= 0) && m_drain && !(m_w == 0 && m_r == 0) &&
             !(hs_b() || hs_rl()) && (m_wd == TO - 1);
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [1:0] exp_gnt();
      if (m_owner < 0) return 2'b00;
      return (m_owner == 1) ? 2'b10 : 2'b01;
   endfunction

   function automatic bit exp_addr();
      if (m_owner < 0 || m_drain) return 1'b0;
      return REQ[m_owner] && (m_w != MAX) && (m_r != MAX);
   endfunction

   always @(posedge ACLK or negedge ARESETN) begin : model
      int nw, nr, nowner, nlast, nwd;
      bit ndrain, to;
      if (!ARESETN) begin
         m_owner <= -1; m_last <= 1; m_w <= 0; m_r <= 0; m_wd <= 0; m_drain <= 1'b0;
      end else begin
         to = exp_to();
         nw = m_w; nr = m_r; nowner = m_owner; nlast = m_last; nwd = 0; ndrain = m_drain;
         if (hs_aw() && !hs_b() && m_w < MAX) nw = m_w + 1;
         else if (hs_b() && !hs_aw() && m_w > 0) nw = m_w - 1;
         if (hs_ar() && !hs_rl() && m_r < MAX) nr = m_r + 1;
         else if (hs_rl() && !hs_ar() && m_r > 0) nr = m_r - 1;
         if (to) begin nw = 0; nr = 0; end
         if (m_owner < 0) begin
            if (REQ != 2'b00) begin
               nowner = (REQ == 2'b11) ? 1 - m_last : (REQ[1] ? 1 : 0);
               nlast  = nowner;
               ndrain = 1'b0;
            end
         end else if (!m_drain) begin
            if (!REQ[m_owner]) ndrain = 1'b1;
         end else if ((m_w == 0 && m_r == 0) || to) begin
            nowner = -1;
            ndrain = 1'b0;
         end else begin
            nwd = (hs_b() || hs_rl()) ? 0 : m_wd + 1;
         end
         m_owner <= nowner; m_last <= nlast; m_w <= nw; m_r <= nr;
         m_wd <= nwd; m_drain <= ndrain;
      end
   end

   always @(negedge ACLK) begin
      check("gnt_model", GNT, exp_gnt());
      check("addr_en_model", ADDR_EN, exp_addr());
      check("timeout_model", TIMEOUT_ERR, exp_to());
      check("wcnt_model", dut.wcnt_q, m_w);
      check("rcnt_model", dut.rcnt_q, m_r);
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   task automatic set_hs(input bit aw, input bit b, input bit ar, input bit r);
      awv = aw; awr = aw; bv = b; br = b; arv = ar; arr = ar; rv = r; rr = r; rl = r;
   endtask

   task automatic pulse_reset();
      ARESETN = 1'b0;
      set_hs(0, 0, 0, 0);
      tick();
      ARESETN = 1'b1;
   endtask

   initial begin
      logic [1:0] seq [3];
      int n;
      int rate_a, rate_r;

      set_hs(0, 0, 0, 0);
      repeat (3) tick();
      check("reset_gnt", GNT, 2'b00);
      check("reset_addr_en", ADDR_EN, 1'b0);
      ARESETN = 1'b1;

      // first grant after reset
      REQ = 2'b01;
      tick();
      check("first_gnt", GNT, 2'b01);
      check("first_addr_en", ADDR_EN, 1'b1);

      // write outstanding limit and saturation
      set_hs(1, 0, 0, 0);
      repeat (4) tick();
      set_hs(0, 0, 0, 0);
      check("wcnt_at_max", dut.wcnt_q, 4);
      check("addr_en_at_max", ADDR_EN, 1'b0);
      set_hs(1, 0, 0, 0); tick(); set_hs(0, 0, 0, 0);
      check("wcnt_saturate", dut.wcnt_q, 4);
      set_hs(0, 1, 0, 0); tick(); set_hs(0, 0, 0, 0);
      check("addr_en_after_b", ADDR_EN, 1'b1);
      check("wcnt_after_b", dut.wcnt_q, 3);
      set_hs(0, 1, 0, 0); repeat (4) tick(); set_hs(0, 0, 0, 0);
      check("wcnt_floor", dut.wcnt_q, 0);

      // simultaneous AR and R-last
      set_hs(0, 0, 1, 0); tick();
      set_hs(0, 0, 1, 1); tick();
      check("rcnt_inc_dec", dut.rcnt_q, 1);
      set_hs(0, 0, 1, 0); tick(); set_hs(0, 0, 0, 0);
      check("rcnt_two", dut.rcnt_q, 2);

      // drain holds grant until both R-last beats
      REQ = 2'b00;
      tick();
      check("drain_gnt", GNT, 2'b01);
      check("drain_addr_en", ADDR_EN, 1'b0);
      REQ = 2'b10;
      repeat (2) tick();
      check("drain_hold_gnt", GNT, 2'b01);
      set_hs(0, 0, 0, 1); tick(); set_hs(0, 0, 0, 0);
      check("drain_after_rl1", GNT, 2'b01);
      set_hs(0, 0, 0, 1); tick(); set_hs(0, 0, 0, 0);
      check("drain_after_rl2", GNT, 2'b01);
      REQ = 2'b00;
      tick();
      check("drain_release", GNT, 2'b00);

      // round-robin with both requesting
      pulse_reset();
      REQ = 2'b11;
      for (int k = 0; k < 3; k++) begin
         n = 0;
         while (GNT == 2'b00 && n < 10) begin tick(); n++; end
         check("rr_wait_grant", (GNT != 2'b00), 1'b1);
         seq[k] = GNT;
         REQ = 2'b11 & ~GNT;
         tick();
         REQ = 2'b11;
         n = 0;
         while (GNT != 2'b00 && n < 10) begin tick(); n++; end
         check("rr_wait_idle", GNT, 2'b00);
      end
      REQ = 2'b00;
      check("rr_seq0", seq[0], 2'b01);
      check("rr_seq1", seq[1], 2'b10);
      check("rr_seq2", seq[2], 2'b01);
      tick();

      // drain watchdog
      pulse_reset();
      REQ = 2'b01; tick();
      set_hs(1, 0, 0, 0); tick(); set_hs(0, 0, 0, 0);
      REQ = 2'b00; tick();
`ifdef AXI_CONN_ARB_TIMEOUT_EN
      for (int i = 1; i <= TO; i++) begin
         check("wd_pulse", TIMEOUT_ERR, (i == TO));
         check("wd_gnt_hold", GNT, 2'b01);
         tick();
      end
      check("wd_idle_gnt", GNT, 2'b00);
      check("wd_wcnt_clear", dut.wcnt_q, 0);
      check("wd_pulse_end", TIMEOUT_ERR, 1'b0);
`else
      for (int i = 1; i <= TO + 4; i++) begin
         check("nowd_pulse", TIMEOUT_ERR, 1'b0);
         check("nowd_gnt_hold", GNT, 2'b01);
         tick();
      end
      set_hs(0, 1, 0, 0); tick(); set_hs(0, 0, 0, 0);
      tick();
      check("nowd_release", GNT, 2'b00);
`endif

      // reset in the middle of a transaction
      REQ = 2'b10; tick();
      set_hs(1, 0, 1, 0); repeat (2) tick();
      ARESETN = 1'b0;
      #1;
      check("midrst_gnt", GNT, 2'b00);
      check("midrst_wcnt", dut.wcnt_q, 0);
      set_hs(0, 0, 0, 0);
      tick();
      ARESETN = 1'b1;

      // randomized traffic
      rate_a = 30; rate_r = 30;
      for (int c = 0; c < 3000; c++) begin
         if (c % 200 == 0) begin
            rate_a = $urandom_range(10, 70);
            rate_r = $urandom_range(0, 50);
         end
         if ($urandom_range(0, 7) == 0) REQ = 2'($urandom_range(0, 3));
         awv = ($urandom_range(0, 99) < rate_a); awr = ($urandom_range(0, 99) < 80);
         arv = ($urandom_range(0, 99) < rate_a); arr = ($urandom_range(0, 99) < 80);
         bv  = ($urandom_range(0, 99) < rate_r); br  = ($urandom_range(0, 99) < 80);
         rv  = ($urandom_range(0, 99) < rate_r); rr  = ($urandom_range(0, 99) < 80);
         rl  = ($urandom_range(0, 99) < 50);
         ARESETN = ($urandom_range(0, 499) != 0);
         tick();
      end
      ARESETN = 1'b1;
      set_hs(0, 0, 0, 0);
      REQ = 2'b00;
      repeat (2) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
